fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Shares the single write port of the async FIFO among N requesters in the write clock domain, using round-robin arbitration.
- Grants one requester at a time for a burst. A burst ends on the requester's last flag, on reaching MAX_BURST beats, or when the requester drops valid.
- Drives the FIFO write data/valid pins and consumes the FIFO full flag.
- Sits between the write-domain producers and the FIFO write interface.

Parameters:
- N, 4, number of requesters (2..16)
- DW, 8, data width; equals the FIFO DW
- MAX_BURST, 4, maximum beats per grant (>=1)

Ports:
- clk  input  1  write-domain clock; connects to the FIFO wr_clk
- rst  input  1  asynchronous, active-high reset
- i_sw_rst  input  1  synchronous clear; same effect as rst, applied on the next clk edge
- i_req_valid  input  N  per-requester data valid
- i_req_data  input  N*DW  requester k occupies bits [k*DW+DW-1 : k*DW]
- i_req_last  input  N  marks the final beat of a requester's packet
- o_req_ready  output  N  per-requester accept strobe
- o_wr_data  output  DW  to FIFO i_wr_data
- o_wr_valid  output  1  to FIFO i_wr_valid
- i_wr_fifo_full  input  1  from FIFO o_wr_fifo_full
- o_grant  output  N  one-hot current owner; all zeros when idle
- o_busy  output  1  high while in GRANT

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. rst is asynchronous; i_sw_rst is synchronous. Both force:
  - state=IDLE, rr_ptr=0, beat_cnt=0, grant=0.
  - All outputs 0: o_req_ready, o_wr_valid, o_wr_data, o_grant, o_busy.
- Beat definition: beat = o_wr_valid & ~i_wr_fifo_full. This matches the FIFO's internal write enable, so an accepted beat is written that same cycle.
- State IDLE:
  - o_wr_valid=0, o_req_ready=0, o_wr_data=0.
  - If |i_req_valid, select the first set bit scanning cyclically from rr_ptr upward: rr_ptr, rr_ptr+1, ... N-1, 0, ...
  - Register grant=that index and beat_cnt=0, then go to GRANT.
  - Arbitration latency: 1 cycle, from valid in IDLE to the first possible beat.
- State GRANT, owner g:
  - o_wr_valid = i_req_valid[g]
  - o_wr_data = data slice g; the slice is muxed combinationally, with no extra latency.
  - o_req_ready[g] = i_req_valid[g] & ~i_wr_fifo_full; all other ready bits are 0.
  - On each beat, beat_cnt increments.
- GRANT exit conditions; each sets rr_ptr=(g+1) mod N, state=IDLE, grant=0 on the next cycle:
  - (a) beat with i_req_last[g]=1;
  - (b) beat with beat_cnt==MAX_BURST-1;
  - (c) i_req_valid[g]==0 in GRANT, i.e. the requester releases; no bubbles are allowed inside a burst.
- Full while granted:
  - Stay in GRANT, no beat, beat_cnt held, o_wr_valid stays at i_req_valid[g].
  - Stalling on full is not a release condition.
  - Data and valid from the requester must be held stable while full is asserted.
- Non-owner requesters: a valid from a non-owner has no effect until the next IDLE; it is never dropped.
- Fairness: each burst costs 1 IDLE cycle. With all requesters continuously valid, the grant order is 0,1,..,N-1,0 and so on.
- beat_cnt width: $clog2(MAX_BURST+1).
- MAX_BURST=1: every grant is exactly one beat.
- i_sw_rst during GRANT:
  - Aborts the burst immediately. Beats already written remain in the FIFO.
  - No beat occurs on the clear cycle: o_req_ready is forced to 0 that cycle.
- o_busy is 1 exactly while in GRANT. o_grant equals onehot(g) while in GRANT and 0 otherwise.

Test Plan:
- Reset/single requester:
  - Stimulus: rst pulse, then req0 valid with 3 beats (data 0x11,0x22,0x33), last on 0x33, full=0.
  - Response: o_grant=0001 one cycle after valid; three consecutive o_wr_valid beats carry 0x11/0x22/0x33; IDLE follows; rr_ptr=1.
- Burst cap:
  - Stimulus: req2 continuously valid, never asserts last, MAX_BURST=4.
  - Response: exactly 4 beats, then 1 IDLE cycle, then req2 is re-granted (it is the only requester) for 4 more beats.
- Round-robin:
  - Stimulus: all four requesters continuously valid with single-beat packets (last=1).
  - Response: grant sequence 0001,0010,0100,1000,0001, with one beat each and an IDLE cycle between grants.
- Full stall:
  - Stimulus: req1 granted, i_wr_fifo_full high for 5 cycles mid-burst after 2 beats.
  - Response: o_req_ready[1]=0 for those 5 cycles, beat_cnt stays 2, grant is held, and remaining beats resume when full drops; total 4 beats.
- Release and clear:
  - Stimulus 1: req3 drops valid after 1 beat → IDLE on the next cycle, rr_ptr=0.
  - Stimulus 2: i_sw_rst asserted mid-burst of req0 → all outputs 0 and state IDLE on the next cycle; with req1 and req0 valid afterwards, req0 is granted first (rr_ptr=0).

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among N write-domain requesters.
// A granted requester owns the port for one burst, which ends on last, MAX_BURST beats, or release.
module fifo_wr_arbiter #(
  parameter int N         = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_sw_rst,
  input  logic [N-1:0]    i_req_valid,
  input  logic [N*DW-1:0] i_req_data,
  input  logic [N-1:0]    i_req_last,
  output logic [N-1:0]    o_req_ready,
  output logic [DW-1:0]   o_wr_data,
  output logic            o_wr_valid,
  input  logic            i_wr_fifo_full,
  output logic [N-1:0]    o_grant,
  output logic            o_busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t          r_state, w_state_nxt;
  logic [IW-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [IW-1:0]   r_gnt, w_gnt_nxt;
  logic [BW-1:0]   r_beat_cnt, w_beat_cnt_nxt;

  logic [2*N-1:0]  w_dbl;
  logic [N-1:0]    w_rot;
  logic [IW-1:0]   w_off;
  logic            w_found;
  logic [IW:0]     w_sum;
  logic [IW-1:0]   w_pick;
  logic [IW:0]     w_inc;
  logic [IW-1:0]   w_gnt_plus1;
  logic            w_owner_valid;
  logic            w_beat;

  // Rotate requests so bit 0 is the rr_ptr requester; the first set bit wins.
  assign w_dbl = {i_req_valid, i_req_valid} >> r_rr_ptr;
  assign w_rot = w_dbl[N-1:0];

  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int i = 0; i < N; i++) begin
      if (!w_found && w_rot[i]) begin
        w_found = 1'b1;
        w_off   = IW'(i);
      end
    end
  end

  assign w_sum       = {1'b0, r_rr_ptr} + {1'b0, w_off};
  assign w_pick      = (w_sum >= (IW+1)'(N)) ? IW'(w_sum - (IW+1)'(N)) : IW'(w_sum);
  assign w_inc       = {1'b0, r_gnt} + (IW+1)'(1);
  assign w_gnt_plus1 = (w_inc == (IW+1)'(N)) ? '0 : IW'(w_inc);

  assign w_owner_valid = i_req_valid[r_gnt];
  assign o_busy        = (r_state == S_GRANT);
  assign o_grant       = o_busy ? (N'(1) << r_gnt) : '0;

  // The sync clear suppresses the write on its own cycle so an aborted burst writes nothing more.
  assign w_beat = o_wr_valid & ~i_wr_fifo_full;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    w_state_nxt    = r_state;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_gnt_nxt      = r_gnt;
    w_beat_cnt_nxt = r_beat_cnt;
    o_wr_valid     = 1'b0;
    o_wr_data      = '0;
    o_req_ready    = '0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt    = S_GRANT;
          w_gnt_nxt      = w_pick;
          w_beat_cnt_nxt = '0;
        end
      end
      S_GRANT: begin
        o_wr_valid = w_owner_valid & ~i_sw_rst;
        o_wr_data  = i_req_data[r_gnt*DW +: DW];
        o_req_ready[r_gnt] = w_beat;
        if (!w_owner_valid) begin
          w_state_nxt  = S_IDLE;
          w_rr_ptr_nxt = w_gnt_plus1;
          w_gnt_nxt    = '0;
        end else if (w_beat) begin
          if (i_req_last[r_gnt] || (r_beat_cnt == BW'(MAX_BURST - 1))) begin
            w_state_nxt  = S_IDLE;
            w_rr_ptr_nxt = w_gnt_plus1;
            w_gnt_nxt    = '0;
          end else begin
            w_beat_cnt_nxt = r_beat_cnt + BW'(1);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_gnt      <= '0;
      r_beat_cnt <= '0;
    end else if (i_sw_rst) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_gnt      <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_gnt      <= w_gnt_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: single burst, burst cap, round-robin, full stall, release, clears.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_sw_rst;
  logic [N-1:0]    i_req_valid;
  logic [N*DW-1:0] i_req_data;
  logic [N-1:0]    i_req_last;
  logic [N-1:0]    o_req_ready;
  logic [DW-1:0]   o_wr_data;
  logic            o_wr_valid;
  logic            i_wr_fifo_full;
  logic [N-1:0]    o_grant;
  logic            o_busy;

  int n_vec = 0;
  int n_err = 0;

  fifo_wr_arbiter #(.N(N), .DW(DW), .MAX_BURST(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_sw_rst       (i_sw_rst),
    .i_req_valid    (i_req_valid),
    .i_req_data     (i_req_data),
    .i_req_last     (i_req_last),
    .o_req_ready    (o_req_ready),
    .o_wr_data      (o_wr_data),
    .o_wr_valid     (o_wr_valid),
    .i_wr_fifo_full (i_wr_fifo_full),
    .o_grant        (o_grant),
    .o_busy         (o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int k, input logic [DW-1:0] v);
    i_req_data[k*DW +: DW] = v;
  endtask

  initial begin
    logic [3:0] exp_oh;
    rst = 1'b1; i_sw_rst = 1'b0; i_req_valid = '0; i_req_data = '0;
    i_req_last = '0; i_wr_fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_grant", 8'(o_grant), 8'h0);
    chk("rst_busy",  8'(o_busy), 8'h0);
    chk("rst_wrv",   8'(o_wr_valid), 8'h0);
    chk("rst_ready", 8'(o_req_ready), 8'h0);
    chk("rst_data",  o_wr_data, 8'h0);

    // Single requester, 3-beat packet
    i_req_valid = 4'b0001; set_data(0, 8'h11);
    #1;
    chk("t1_idle_grant", 8'(o_grant), 8'h0);
    chk("t1_idle_wrv",   8'(o_wr_valid), 8'h0);
    cyc(); #1;
    chk("t1_b1_grant", 8'(o_grant), 8'h1);
    chk("t1_b1_busy",  8'(o_busy), 8'h1);
    chk("t1_b1_wrv",   8'(o_wr_valid), 8'h1);
    chk("t1_b1_data",  o_wr_data, 8'h11);
    chk("t1_b1_ready", 8'(o_req_ready), 8'h1);
    cyc(); set_data(0, 8'h22); #1;
    chk("t1_b2_data",  o_wr_data, 8'h22);
    cyc(); set_data(0, 8'h33); i_req_last = 4'b0001; #1;
    chk("t1_b3_data",  o_wr_data, 8'h33);
    chk("t1_b3_ready", 8'(o_req_ready), 8'h1);
    cyc(); i_req_valid = '0; i_req_last = '0; #1;
    chk("t1_end_grant", 8'(o_grant), 8'h0);
    chk("t1_end_busy",  8'(o_busy), 8'h0);

    // Burst cap: req2 never sends last
    i_req_valid = 4'b0100;
    for (int rep = 0; rep < 2; rep++) begin
      #1 chk("t2_idle_grant", 8'(o_grant), 8'h0);
      for (int b = 0; b < 4; b++) begin
        cyc(); set_data(2, 8'hA0 + 8'(b)); #1;
        chk("t2_grant", 8'(o_grant), 8'h4);
        chk("t2_data",  o_wr_data, 8'hA0 + 8'(b));
      end
      cyc();
    end
    i_req_valid = '0; #1;
    chk("t2_end_grant", 8'(o_grant), 8'h0);
    chk("t2_end_wrv",   8'(o_wr_valid), 8'h0);

    // Sync clear in IDLE resets rr_ptr (was 3), then round-robin over all four
    cyc(); i_sw_rst = 1'b1;
    cyc(); i_sw_rst = 1'b0;
    i_req_valid = 4'b1111; i_req_last = 4'b1111;
    for (int k = 0; k < N; k++) set_data(k, 8'h40 + 8'(k));
    #1 chk("t3_idle_grant", 8'(o_grant), 8'h0);
    for (int i = 0; i < 5; i++) begin
      exp_oh = 4'b0001 << (i % 4);
      cyc(); #1;
      chk("t3_grant", 8'(o_grant), 8'(exp_oh));
      chk("t3_ready", 8'(o_req_ready), 8'(exp_oh));
      chk("t3_data",  o_wr_data, 8'h40 + 8'(i % 4));
      cyc();
      if (i == 4) i_req_valid = '0;
      #1 chk("t3_gap_grant", 8'(o_grant), 8'h0);
    end
    i_req_last = '0;

    // Full stall: req1 (rr_ptr=1), 2 beats, 5 full cycles, 2 more beats
    i_req_valid = 4'b0010; set_data(1, 8'hB0);
    cyc(); #1;
    chk("t4_b1_grant", 8'(o_grant), 8'h2);
    chk("t4_b1_ready", 8'(o_req_ready), 8'h2);
    chk("t4_b1_data",  o_wr_data, 8'hB0);
    cyc(); set_data(1, 8'hB1); #1;
    chk("t4_b2_ready", 8'(o_req_ready), 8'h2);
    cyc(); i_wr_fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t4_full_ready", 8'(o_req_ready), 8'h0);
      chk("t4_full_grant", 8'(o_grant), 8'h2);
      chk("t4_full_wrv",   8'(o_wr_valid), 8'h1);
      cyc();
    end
    i_wr_fifo_full = 1'b0; set_data(1, 8'hB2); #1;
    chk("t4_b3_ready", 8'(o_req_ready), 8'h2);
    chk("t4_b3_data",  o_wr_data, 8'hB2);
    cyc(); set_data(1, 8'hB3); #1;
    chk("t4_b4_ready", 8'(o_req_ready), 8'h2);
    cyc(); i_req_valid = '0; #1;
    chk("t4_end_grant", 8'(o_grant), 8'h0);

    // Release: req3 drops valid after one beat
    i_req_valid = 4'b1000; set_data(3, 8'hD0);
    cyc(); #1;
    chk("t5_grant", 8'(o_grant), 8'h8);
    chk("t5_ready", 8'(o_req_ready), 8'h8);
    cyc(); i_req_valid = '0; #1;
    chk("t5_rel_wrv",   8'(o_wr_valid), 8'h0);
    chk("t5_rel_ready", 8'(o_req_ready), 8'h0);
    chk("t5_rel_grant", 8'(o_grant), 8'h8);
    cyc(); #1;
    chk("t5_idle_grant", 8'(o_grant), 8'h0);
    chk("t5_idle_busy",  8'(o_busy), 8'h0);

    // rr_ptr=0 after release of req3; then sync clear mid-burst of req0
    i_req_valid = 4'b0011; set_data(0, 8'hC0); set_data(1, 8'hC1);
    cyc(); #1;
    chk("t6_grant", 8'(o_grant), 8'h1);
    chk("t6_data",  o_wr_data, 8'hC0);
    chk("t6_ready", 8'(o_req_ready), 8'h1);
    cyc(); i_sw_rst = 1'b1; #1;
    chk("t6_clr_ready", 8'(o_req_ready), 8'h0);
    chk("t6_clr_wrv",   8'(o_wr_valid), 8'h0);
    cyc(); i_sw_rst = 1'b0; #1;
    chk("t6_post_grant", 8'(o_grant), 8'h0);
    chk("t6_post_busy",  8'(o_busy), 8'h0);
    chk("t6_post_wrv",   8'(o_wr_valid), 8'h0);
    chk("t6_post_ready", 8'(o_req_ready), 8'h0);
    chk("t6_post_data",  o_wr_data, 8'h0);
    cyc(); #1;
    chk("t6_regrant", 8'(o_grant), 8'h1);

    // Async reset mid-grant takes effect without a clock edge
    #1 rst = 1'b1;
    #1;
    chk("t7_arst_grant", 8'(o_grant), 8'h0);
    chk("t7_arst_busy",  8'(o_busy), 8'h0);
    chk("t7_arst_wrv",   8'(o_wr_valid), 8'h0);
    rst = 1'b0; i_req_valid = '0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
